fifo_sync_prog: RTL and testbench

//  Parametrised single-clock synchronous FIFO; successor to the fixed 16x8 FIFO.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_ram.sv | 32 +++
 rtl/fifo_sync_prog.sv | 131 +++++++++++++
 tb/tb_fifo_sync_prog.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, width helper and status struct for fifo_sync_prog
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    // Width that can hold every occupancy value 0..depth inclusive.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
//  clk    : write clock
//  we     : write enable
//  waddr  : write address
//  wdata  : write data
//  raddr  : read address
//  rdata  : read data, combinational from raddr
module fifo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FIFO with programmable thresholds, flush and optional FWFT read
//  clk, rst_n             : clock, asynchronous active-low reset
//  flush                  : synchronous clear, dominates wr_en/rd_en
//  data_in, wr_en         : write side
//  rd_en, data_out        : read side (registered or first-word-fall-through)
//  af_thresh, ae_thresh   : almost-full / almost-empty thresholds
//  count                  : occupancy 0..FIFO_DEPTH
//  full, empty, almostfull, almostempty : combinational status
//  wr_ack, overflow, underflow          : registered one-cycle pulses
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FWFT       = 0,
    localparam int CW        = fifo_cw(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [FIFO_WIDTH-1:0] ram_rdata;
    logic                  wr_acc;
    logic                  rd_acc;
    fifo_status_t          status;

    always_comb begin
        status.full        = (count_q == CW'(FIFO_DEPTH));
        status.empty       = (count_q == '0);
        status.almostfull  = (count_q >= af_thresh);
        status.almostempty = (count_q <= ae_thresh);
    end

    // Gating on full/empty alone resolves the simultaneous cases:
    // full -> only the read goes through, empty -> only the write does.
    assign wr_acc = wr_en && !status.full  && !flush;
    assign rd_acc = rd_en && !status.empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Explicit wrap so non-power-of-2 depths work.
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= wr_en && status.full;
            underflow <= rd_en && status.empty;
        end
    end

    fifo_ram #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is meaningless while empty; drive zero so nothing
            // uninitialised from the RAM ever reaches the output.
            assign data_out = status.empty ? '0 : ram_rdata;
        end else begin : g_reg
            logic [FIFO_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= ram_rdata;
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

    assign count       = count_q;
    assign full        = status.full;
    assign empty       = status.empty;
    assign almostfull  = status.almostfull;
    assign almostempty = status.almostempty;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - self-checking bench for fifo_sync_prog, registered and FWFT variants
module tb_fifo_sync_prog;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [W-1:0]  data_in;
    logic          wr_en;
    logic          rd_en;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;

    logic [W-1:0]  dout_r,  dout_f;
    logic [CW-1:0] cnt_r,   cnt_f;
    logic          full_r,  full_f;
    logic          empty_r, empty_f;
    logic          af_r,    af_f;
    logic          ae_r,    ae_f;
    logic          ack_r,   ack_f;
    logic          ovf_r,   ovf_f;
    logic          unf_r,   unf_f;

    always #5 clk = ~clk;

    fifo_sync_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
        .wr_en(wr_en), .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .data_out(dout_r), .count(cnt_r), .full(full_r), .empty(empty_r),
        .almostfull(af_r), .almostempty(ae_r), .wr_ack(ack_r),
        .overflow(ovf_r), .underflow(unf_r)
    );

    fifo_sync_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
        .wr_en(wr_en), .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .data_out(dout_f), .count(cnt_f), .full(full_f), .empty(empty_f),
        .almostfull(af_f), .almostempty(ae_f), .wr_ack(ack_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    // Reference model: contents as a queue, plus the expected registered outputs.
    int          q[$];
    int          m_dout;
    logic        m_ack, m_ovf, m_unf;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_clock();
        int  n;
        logic wacc, racc;
        n = q.size();
        if (flush) begin
            q.delete();
            m_ack = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wacc  = wr_en && (n != D);
            racc  = rd_en && (n != 0);
            m_ack = wacc;
            m_ovf = wr_en && (n == D);
            m_unf = rd_en && (n == 0);
            if (racc) m_dout = q.pop_front();
            if (wacc) q.push_back(int'(data_in));
        end
    endtask

    task automatic check_all(input string ph);
        int c;
        c = q.size();
        chk({ph, ".count_r"}, 32'(cnt_r),   32'(c));
        chk({ph, ".count_f"}, 32'(cnt_f),   32'(c));
        chk({ph, ".full_r"},  32'(full_r),  32'(c == D));
        chk({ph, ".full_f"},  32'(full_f),  32'(c == D));
        chk({ph, ".empty_r"}, 32'(empty_r), 32'(c == 0));
        chk({ph, ".empty_f"}, 32'(empty_f), 32'(c == 0));
        chk({ph, ".af_r"},    32'(af_r),    32'(c >= int'(af_thresh)));
        chk({ph, ".af_f"},    32'(af_f),    32'(c >= int'(af_thresh)));
        chk({ph, ".ae_r"},    32'(ae_r),    32'(c <= int'(ae_thresh)));
        chk({ph, ".ae_f"},    32'(ae_f),    32'(c <= int'(ae_thresh)));
        chk({ph, ".ack_r"},   32'(ack_r),   32'(m_ack));
        chk({ph, ".ack_f"},   32'(ack_f),   32'(m_ack));
        chk({ph, ".ovf_r"},   32'(ovf_r),   32'(m_ovf));
        chk({ph, ".ovf_f"},   32'(ovf_f),   32'(m_ovf));
        chk({ph, ".unf_r"},   32'(unf_r),   32'(m_unf));
        chk({ph, ".unf_f"},   32'(unf_f),   32'(m_unf));
        chk({ph, ".dout_r"},  32'(dout_r),  32'(m_dout));
        if (c != 0) chk({ph, ".dout_f"}, 32'(dout_f), 32'(q[0]));
    endtask

    // One clock with the given inputs; checks land 1ns after the edge.
    task automatic step(input string ph, input logic w, input logic r,
                        input logic [W-1:0] d, input logic f = 1'b0);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        flush   = f;
        @(posedge clk);
        model_clock();
        #1;
        check_all(ph);
    endtask

    initial begin
        int save;
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        af_thresh = 4'd7; ae_thresh = 4'd1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, W'(i));
        step("ovf_wr", 1'b1, 1'b0, 16'h00AA);
        step("ovf_idle", 1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= 8; i++) begin
            if (q.size() != 0) chk("fwft_head", 32'(dout_f), 32'(i));
            step("drain", 1'b0, 1'b1, 16'h0);
            chk("drain_order", 32'(dout_r), 32'(i));
        end
        step("unf_rd", 1'b0, 1'b1, 16'h0);

        step("wr_rd_empty", 1'b1, 1'b1, 16'h0101);
        for (int i = 0; i < 7; i++) step("refill", 1'b1, 1'b0, W'(16'h0200 + i));
        step("wr_rd_full", 1'b1, 1'b1, 16'h0BAD);
        for (int i = 0; i < 3; i++) step("down4", 1'b0, 1'b1, 16'h0);
        step("wr_rd_mid", 1'b1, 1'b1, 16'h0444);
        step("to5", 1'b1, 1'b0, 16'h0555);
        save = m_dout;
        step("flush", 1'b0, 1'b0, 16'h0, 1'b1);
        chk("flush_hold", 32'(dout_r), 32'(save));

        for (int i = 0; i < 3; i++) step("pre_wrap", 1'b1, 1'b0, W'($urandom));
        for (int i = 0; i < 20; i++) step("wrap", 1'b1, 1'b1, W'($urandom));
        af_thresh = 4'd3;
        #1;
        check_all("af_now");
        af_thresh = 4'd7;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                af_thresh = CW'($urandom_range(0, 9));
                ae_thresh = CW'($urandom_range(0, 9));
            end
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 W'($urandom), 1'($urandom_range(0, 19) == 0));
        end

        af_thresh = 4'd7; ae_thresh = 4'd1;
        for (int i = 0; i < 4; i++) step("burst", 1'b1, 1'b0, W'($urandom));
        wr_en = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("rst_dout_f", 32'(dout_f), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step("post_rst", 1'b1, 1'($urandom_range(0, 1)), W'($urandom));
        for (int i = 0; i < 8; i++) step("final_drain", 1'b0, 1'b1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
